mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high; rdy in 1 global enable, all state frozen while low.
REQ-002 SHALL have ports: flush in 1 misbranch flush; io_buffer_full in 1 UART buffer full.
REQ-003 SHALL have fetch port: if_req in 1 pulse; if_addr in 32; if_done out 1 pulse.
REQ-004 SHALL have load port: ld_req in 1 pulse; ld_addr in 32; ld_size in 3 (1/2/4 bytes); ld_signed in 1; ld_done out 1 pulse.
REQ-005 SHALL have store port: st_req in 1 pulse; st_addr in 32; st_size in 3; st_data in 32; st_done out 1 pulse.
REQ-006 SHALL have rdata out 32, valid in the if_done/ld_done cycle.
REQ-007 SHALL have downstream port: mem_req out 1 pulse; mem_we out 1; mem_addr out 32; mem_size out 3; mem_signed out 1; mem_wdata out 32; mem_done in 1; mem_rdata in 32.

Function
REQ-008 SHALL latch each port's payload and set a pending flag on the edge where its *_req is high; a re-request while pending overwrites the payload.
REQ-009 SHALL run FSM IDLE/BUSY/DRAIN; reset state IDLE.
REQ-010 In IDLE with any eligible pending flag, SHALL grant on the next edge: drive mem_req high for exactly one cycle with the granted payload, clear that pending flag, and enter BUSY.
REQ-011 Grant priority SHALL be store > load > fetch (strict, unless REQ-021 applies).
REQ-012 A store whose st_addr[17:16]==2'b11 SHALL be ineligible while io_buffer_full is high; lower-priority ports may be granted meanwhile.
REQ-013 In BUSY, on mem_done, SHALL register mem_rdata into rdata, pulse the owner's *_done for one cycle on the next edge, and return to IDLE.
REQ-014 Minimum latency SHALL be: *_req at edge N, mem_req high after edge N+1, and *_done 1 cycle after mem_done.
REQ-015 mem_addr/mem_size/mem_we/mem_wdata/mem_signed SHALL stay stable from grant until mem_done.
REQ-016 On flush, SHALL clear fetch and load pending flags; a same-cycle if_req/ld_req SHALL be dropped.
REQ-017 On flush while BUSY owned by fetch or load, SHALL enter DRAIN, wait for mem_done, suppress the done pulse, then go to IDLE.
REQ-018 Flush SHALL NOT affect a pending or in-flight store; st_done SHALL still pulse.
REQ-019 mem_done while IDLE SHALL be ignored.

Reset
REQ-020 On rst, SHALL clear all pending flags, set state IDLE, drive all *_done, mem_req, and mem_we to 0, set rdata/mem_addr/mem_wdata to 0, mem_size to 0, and mem_signed to 0.

Configuration
REQ-021 With STARVE_GUARD_EN defined: a 3-bit counter SHALL count grants to store/load while fetch is pending; at 4, fetch SHALL win the next grant and the counter SHALL clear. The counter SHALL also clear on any fetch grant or flush.
REQ-022 Without STARVE_GUARD_EN: strict priority, and no counter logic SHALL be present.

Structure
REQ-023 Port IDs (NONE/IF/LD/ST), FSM state codes, size codes, and IO region bits SHALL live in the shared constants header.
REQ-024 The combinational priority/eligibility picker SHALL be sub-module arb_pick; sequencing SHALL stay in mem_arbiter.

Verification
REQ-025 Same-cycle if_req(0x100), ld_req(0x2000, size 4), st_req(0x3000, data 0xDEADBEEF, size 4) -> grants in order store, load, fetch; each *_done pulses once.
REQ-026 Load at 0x40 size 1 signed, downstream returns mem_rdata=0xFFFFFF80 -> mem_signed=1 during the transaction; ld_done pulses with rdata=0xFFFFFF80.
REQ-027 Store to 0x30000 with io_buffer_full=1 plus if_req -> fetch is granted first; the store is granted only after io_buffer_full drops.
REQ-028 flush while a fetch is BUSY and a load is pending -> no if_done or ld_done; the FSM returns to IDLE after mem_done; a pending store still completes.
REQ-029 STARVE_GUARD_EN: continuous load requests plus a pending fetch -> fetch is granted after exactly 4 load grants; without the macro, fetch is never granted.
REQ-030 rdy low mid-BUSY for 5 cycles -> outputs hold; the transaction completes normally when rdy returns high.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the memory arbiter slice.
//   port_e       requester IDs (NONE/IF/LD/ST)
//   S_*          arbiter FSM state codes
//   SIZE_*       access size codes carried on mem_size
//   IO_*         address bits that select the UART/IO region
//   mem_cmd_t    payload presented downstream on a grant
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_IF   = 2'd1,
        PORT_LD   = 2'd2,
        PORT_ST   = 2'd3
    } port_e;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] SIZE_NONE = 3'd0;
    localparam logic [2:0] SIZE_B    = 3'd1;
    localparam logic [2:0] SIZE_H    = 3'd2;
    localparam logic [2:0] SIZE_W    = 3'd4;

    localparam int unsigned IO_BIT_HI = 17;
    localparam int unsigned IO_BIT_LO = 16;
    localparam logic [1:0]  IO_REGION = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        we;
        logic        sgn;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic logic in_io_region(input logic [31:0] addr);
        return addr[IO_BIT_HI:IO_BIT_LO] == IO_REGION;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the request ports, downstream memory port and
// sideband inputs of mem_arbiter.
//   slave  - arbiter view: takes requests/mem responses, drives done/rdata/mem_*
//   master - environment view (core + memory model): the reverse directions
interface mem_arbiter_if;
    logic        flush;
    logic        io_buffer_full;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic        ld_signed;
    logic        ld_done;

    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_size;
    logic [31:0] st_data;
    logic        st_done;

    logic [31:0] rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport slave (
        input  flush, io_buffer_full,
        input  if_req, if_addr,
        input  ld_req, ld_addr, ld_size, ld_signed,
        input  st_req, st_addr, st_size, st_data,
        input  mem_done, mem_rdata,
        output if_done, ld_done, st_done, rdata,
        output mem_req, mem_we, mem_addr, mem_size, mem_signed, mem_wdata
    );

    modport master (
        output flush, io_buffer_full,
        output if_req, if_addr,
        output ld_req, ld_addr, ld_size, ld_signed,
        output st_req, st_addr, st_size, st_data,
        output mem_done, mem_rdata,
        input  if_done, ld_done, st_done, rdata,
        input  mem_req, mem_we, mem_addr, mem_size, mem_signed, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational eligibility + priority picker.
//   st_pend_i/ld_pend_i/if_pend_i  pending flags
//   st_io_i      pending store targets the IO region
//   io_full_i    UART buffer full (blocks IO-region stores only)
//   flush_i      kills fetch/load candidates this cycle
//   force_if_i   starvation override: fetch wins if eligible
//   grant_o      chosen port, PORT_NONE when nothing is eligible
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic  st_pend_i,
    input  logic  st_io_i,
    input  logic  io_full_i,
    input  logic  ld_pend_i,
    input  logic  if_pend_i,
    input  logic  flush_i,
    input  logic  force_if_i,
    output port_e grant_o
);
    logic st_ok;
    logic ld_ok;
    logic if_ok;

    assign st_ok = st_pend_i && !(st_io_i && io_full_i);
    assign ld_ok = ld_pend_i && !flush_i;
    assign if_ok = if_pend_i && !flush_i;

    always_comb begin
        grant_o = PORT_NONE;
        if (force_if_i && if_ok) begin
            grant_o = PORT_IF;
        end else if (st_ok) begin
            grant_o = PORT_ST;
        end else if (ld_ok) begin
            grant_o = PORT_LD;
        end else if (if_ok) begin
            grant_o = PORT_IF;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter of fetch, load and store requests
// onto one downstream memory port.
//   clk, rst  clock, synchronous active-high reset
//   rdy       global enable; all state holds while low
//   bus       mem_arbiter_if.slave: request ports (if_/ld_/st_), done pulses,
//             rdata, flush, io_buffer_full and the downstream mem_* port
// Build option: define STARVE_GUARD_EN to force a fetch grant after four
// consecutive store/load grants taken while a fetch was waiting.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst,
    input logic          rdy,
    mem_arbiter_if.slave bus
);
    logic [1:0]  state_q,     state_d;
    port_e       owner_q,     owner_d;
    mem_cmd_t    cmd_q,       cmd_d;
    logic        mem_req_q,   mem_req_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        if_done_q,   if_done_d;
    logic        ld_done_q,   ld_done_d;
    logic        st_done_q,   st_done_d;

    logic        if_pend_q,   if_pend_d;
    logic [31:0] if_addr_q,   if_addr_d;
    logic        ld_pend_q,   ld_pend_d;
    logic [31:0] ld_addr_q,   ld_addr_d;
    logic [2:0]  ld_size_q,   ld_size_d;
    logic        ld_signed_q, ld_signed_d;
    logic        st_pend_q,   st_pend_d;
    logic [31:0] st_addr_q,   st_addr_d;
    logic [2:0]  st_size_q,   st_size_d;
    logic [31:0] st_data_q,   st_data_d;

    port_e       grant;
    logic        force_if;
    logic        st_io;

    assign st_io = in_io_region(st_addr_q);

    arb_pick u_pick (
        .st_pend_i  (st_pend_q),
        .st_io_i    (st_io),
        .io_full_i  (bus.io_buffer_full),
        .ld_pend_i  (ld_pend_q),
        .if_pend_i  (if_pend_q),
        .flush_i    (bus.flush),
        .force_if_i (force_if),
        .grant_o    (grant)
    );

`ifdef STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;

    assign force_if = (starve_q == 3'd4);

    always_comb begin
        starve_d = starve_q;
        if (bus.flush) begin
            starve_d = '0;
        end else if (state_q == S_IDLE) begin
            if (grant == PORT_IF) begin
                starve_d = '0;
            end else if ((grant == PORT_LD || grant == PORT_ST) && if_pend_q
                         && starve_q != 3'd4) begin
                starve_d = starve_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (rdy) begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        mem_req_d   = 1'b0;
        if_done_d   = 1'b0;
        ld_done_d   = 1'b0;
        st_done_d   = 1'b0;
        if_pend_d   = if_pend_q;
        if_addr_d   = if_addr_q;
        ld_pend_d   = ld_pend_q;
        ld_addr_d   = ld_addr_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        st_pend_d   = st_pend_q;
        st_addr_d   = st_addr_q;
        st_size_d   = st_size_q;
        st_data_d   = st_data_q;

        case (state_q)
            S_IDLE: begin
                if (grant != PORT_NONE) begin
                    mem_req_d = 1'b1;
                    owner_d   = grant;
                    state_d   = S_BUSY;
                    cmd_d     = '0;
                    case (grant)
                        PORT_ST: begin
                            cmd_d.addr  = st_addr_q;
                            cmd_d.size  = st_size_q;
                            cmd_d.we    = 1'b1;
                            cmd_d.wdata = st_data_q;
                            st_pend_d   = 1'b0;
                        end
                        PORT_LD: begin
                            cmd_d.addr = ld_addr_q;
                            cmd_d.size = ld_size_q;
                            cmd_d.sgn  = ld_signed_q;
                            ld_pend_d  = 1'b0;
                        end
                        default: begin
                            cmd_d.addr = if_addr_q;
                            cmd_d.size = SIZE_W;
                            if_pend_d  = 1'b0;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                // A flushed fetch/load that completes on the flush edge needs no drain.
                if (bus.flush && owner_q != PORT_ST) begin
                    state_d = bus.mem_done ? S_IDLE : S_DRAIN;
                end else if (bus.mem_done) begin
                    rdata_d   = bus.mem_rdata;
                    if_done_d = (owner_q == PORT_IF);
                    ld_done_d = (owner_q == PORT_LD);
                    st_done_d = (owner_q == PORT_ST);
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Applied after the grant clear so a same-edge request re-arms its port.
        if (bus.flush) begin
            if_pend_d = 1'b0;
            ld_pend_d = 1'b0;
        end
        if (bus.if_req && !bus.flush) begin
            if_pend_d = 1'b1;
            if_addr_d = bus.if_addr;
        end
        if (bus.ld_req && !bus.flush) begin
            ld_pend_d   = 1'b1;
            ld_addr_d   = bus.ld_addr;
            ld_size_d   = bus.ld_size;
            ld_signed_d = bus.ld_signed;
        end
        if (bus.st_req) begin
            st_pend_d = 1'b1;
            st_addr_d = bus.st_addr;
            st_size_d = bus.st_size;
            st_data_d = bus.st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= PORT_NONE;
            cmd_q       <= '0;
            mem_req_q   <= 1'b0;
            rdata_q     <= '0;
            if_done_q   <= 1'b0;
            ld_done_q   <= 1'b0;
            st_done_q   <= 1'b0;
            if_pend_q   <= 1'b0;
            if_addr_q   <= '0;
            ld_pend_q   <= 1'b0;
            ld_addr_q   <= '0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            st_pend_q   <= 1'b0;
            st_addr_q   <= '0;
            st_size_q   <= '0;
            st_data_q   <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            mem_req_q   <= mem_req_d;
            rdata_q     <= rdata_d;
            if_done_q   <= if_done_d;
            ld_done_q   <= ld_done_d;
            st_done_q   <= st_done_d;
            if_pend_q   <= if_pend_d;
            if_addr_q   <= if_addr_d;
            ld_pend_q   <= ld_pend_d;
            ld_addr_q   <= ld_addr_d;
            ld_size_q   <= ld_size_d;
            ld_signed_q <= ld_signed_d;
            st_pend_q   <= st_pend_d;
            st_addr_q   <= st_addr_d;
            st_size_q   <= st_size_d;
            st_data_q   <= st_data_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = cmd_q.we;
    assign bus.mem_addr   = cmd_q.addr;
    assign bus.mem_size   = cmd_q.size;
    assign bus.mem_signed = cmd_q.sgn;
    assign bus.mem_wdata  = cmd_q.wdata;
    assign bus.rdata      = rdata_q;
    assign bus.if_done    = if_done_q;
    assign bus.ld_done    = ld_done_q;
    assign bus.st_done    = st_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A transaction-level
// reference model predicts every grant and done pulse (with its edge);
// a monitor pops and compares whenever the DUT shows mem_req or a done.
module tb_mem_arbiter;
    localparam int P_IF = 0;
    localparam int P_LD = 1;
    localparam int P_ST = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          port;
        int unsigned due;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        we;
        logic        sgn;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          port;
        int unsigned due;
        logic [31:0] rdata;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    int     dlog[$];

    // reference model state: one slot per requester
    bit          m_pend[3];
    logic [31:0] m_addr[3];
    logic [2:0]  m_size[3];
    logic        m_sgn;
    logic [31:0] m_data;
    bit          m_busy  = 0;
    bit          m_drain = 0;
    int          m_owner = 0;
    int          m_cnt   = 0;

    bit          auto_mem      = 1;
    bit          rdata_force_en = 0;
    logic [31:0] rdata_force   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [2:0] rand_size();
        case ($urandom_range(0, 2))
            0:       return 3'd1;
            1:       return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Predict the effect of the coming clock edge from current inputs.
    task automatic model_step();
        bit     el[3];
        int     pick;
        grant_t g;
        done_t  d;
        if (rst) begin
            for (int p = 0; p < 3; p++) m_pend[p] = 0;
            m_busy = 0; m_drain = 0; m_cnt = 0;
            return;
        end
        if (!rdy) return;
        el[P_IF] = m_pend[P_IF] && !bus.flush;
        el[P_LD] = m_pend[P_LD] && !bus.flush;
        el[P_ST] = m_pend[P_ST] && !(m_addr[P_ST][17:16] == 2'b11 && bus.io_buffer_full);
        pick = -1;
        if (!m_busy && !m_drain) begin
`ifdef STARVE_GUARD_EN
            if (m_cnt >= 4 && el[P_IF]) pick = P_IF;
`endif
            for (int p = P_ST; p >= P_IF; p--)
                if (pick < 0 && el[p]) pick = p;
            if (pick >= 0) begin
                g.port  = pick;
                g.due   = edge_no + 1;
                g.addr  = m_addr[pick];
                g.size  = (pick == P_IF) ? 3'd4 : m_size[pick];
                g.we    = (pick == P_ST);
                g.sgn   = (pick == P_LD) && m_sgn;
                g.wdata = (pick == P_ST) ? m_data : 32'h0;
                gq.push_back(g);
                m_busy  = 1;
                m_owner = pick;
                if (pick == P_IF) m_cnt = 0;
                else if (m_pend[P_IF]) m_cnt++;
                m_pend[pick] = 0;
            end
        end else if (m_drain) begin
            if (bus.mem_done) m_drain = 0;
        end else begin
            if (bus.flush && m_owner != P_ST) begin
                m_busy  = 0;
                m_drain = !bus.mem_done;
            end else if (bus.mem_done) begin
                d.port  = m_owner;
                d.due   = edge_no + 1;
                d.rdata = bus.mem_rdata;
                dq.push_back(d);
                m_busy = 0;
            end
        end
        if (bus.flush) begin
            m_pend[P_IF] = 0; m_pend[P_LD] = 0; m_cnt = 0;
        end
        if (bus.if_req && !bus.flush) begin
            m_pend[P_IF] = 1; m_addr[P_IF] = bus.if_addr;
        end
        if (bus.ld_req && !bus.flush) begin
            m_pend[P_LD] = 1; m_addr[P_LD] = bus.ld_addr;
            m_size[P_LD] = bus.ld_size; m_sgn = bus.ld_signed;
        end
        if (bus.st_req) begin
            m_pend[P_ST] = 1; m_addr[P_ST] = bus.st_addr;
            m_size[P_ST] = bus.st_size; m_data = bus.st_data;
        end
    endtask

    // Called at a negedge with inputs set; advances to the next negedge.
    task automatic step();
        if (auto_mem) begin
            bus.mem_done  = (m_busy || m_drain) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 15) == 0);
            bus.mem_rdata = rdata_force_en ? rdata_force : $urandom();
        end
        model_step();
        @(negedge clk);
        bus.if_req = 0; bus.ld_req = 0; bus.st_req = 0; bus.flush = 0;
    endtask

    task automatic settle(input int max);
        int k = 0;
        rdy = 1; auto_mem = 1; bus.io_buffer_full = 0;
        while ((m_busy || m_drain || m_pend[0] || m_pend[1] || m_pend[2]) && k < max) begin
            step();
            k++;
        end
        if (m_busy || m_drain || m_pend[0] || m_pend[1] || m_pend[2])
            fail("settle_timeout", $sformatf("model still active after %0d cycles, required idle", max));
        step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    grant_t last_g;
    bit     have_last = 0;
    initial begin
        bit s_rdy, s_rst;
        grant_t g;
        done_t  d;
        forever begin
            @(posedge clk);
            s_rdy = rdy; s_rst = rst;
            #1;
            if (!s_rst) begin
                if (!s_rdy) begin
                    if (have_last) begin
                        check("hold_mem_addr", bus.mem_addr, last_g.addr);
                        check("hold_mem_we", 32'(bus.mem_we), 32'(last_g.we));
                        check("hold_mem_size", 32'(bus.mem_size), 32'(last_g.size));
                    end
                end else begin
                    while (gq.size() > 0 && gq[0].due < edge_no) begin
                        fail("grant_missing", $sformatf("no mem_req at edge %0d, required one", gq[0].due));
                        void'(gq.pop_front());
                    end
                    while (dq.size() > 0 && dq[0].due < edge_no) begin
                        fail("done_missing", $sformatf("no done for port %0d at edge %0d, required one",
                                                       dq[0].port, dq[0].due));
                        void'(dq.pop_front());
                    end
                    if (bus.mem_req) begin
                        if (gq.size() == 0) begin
                            fail("grant_unexpected", $sformatf("mem_req=1 addr 0x%08h at edge %0d, required none",
                                                               bus.mem_addr, edge_no));
                        end else begin
                            g = gq.pop_front();
                            check("grant_edge", edge_no, g.due);
                            check("mem_addr", bus.mem_addr, g.addr);
                            check("mem_size", 32'(bus.mem_size), 32'(g.size));
                            check("mem_we", 32'(bus.mem_we), 32'(g.we));
                            check("mem_signed", 32'(bus.mem_signed), 32'(g.sgn));
                            check("mem_wdata", bus.mem_wdata, g.wdata);
                            last_g = g;
                            have_last = 1;
                        end
                    end
                    for (int p = 0; p < 3; p++) begin
                        logic dn;
                        dn = (p == P_IF) ? bus.if_done : (p == P_LD) ? bus.ld_done : bus.st_done;
                        if (dn) begin
                            dlog.push_back(p);
                            if (dq.size() == 0) begin
                                fail("done_unexpected", $sformatf("done on port %0d at edge %0d, required none",
                                                                  p, edge_no));
                            end else begin
                                d = dq.pop_front();
                                check("done_port", p, d.port);
                                check("done_edge", edge_no, d.due);
                                if (p != P_ST) check("rdata", bus.rdata, d.rdata);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_if;
        rst = 1; rdy = 1;
        bus.flush = 0; bus.io_buffer_full = 0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_signed = 0;
        bus.st_req = 0; bus.st_addr = '0; bus.st_size = '0; bus.st_data = '0;
        bus.mem_done = 0; bus.mem_rdata = '0;
        @(negedge clk);
        auto_mem = 0;
        repeat (3) step();
        rst = 0;
        check("rst_if_done", 32'(bus.if_done), 0);
        check("rst_ld_done", 32'(bus.ld_done), 0);
        check("rst_st_done", 32'(bus.st_done), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_size", 32'(bus.mem_size), 0);
        check("rst_mem_signed", 32'(bus.mem_signed), 0);
        check("rst_rdata", bus.rdata, 0);
        auto_mem = 1;

        // same-cycle fetch/load/store: store, load, fetch order
        dlog.delete();
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.ld_req = 1; bus.ld_addr = 32'h2000; bus.ld_size = 3'd4; bus.ld_signed = 0;
        bus.st_req = 1; bus.st_addr = 32'h3000; bus.st_size = 3'd4; bus.st_data = 32'hDEADBEEF;
        step();
        settle(200);
        check("prio_count", dlog.size(), 3);
        if (dlog.size() == 3) begin
            check("prio_first", dlog[0], P_ST);
            check("prio_second", dlog[1], P_LD);
            check("prio_third", dlog[2], P_IF);
        end

        // signed byte load
        dlog.delete();
        rdata_force_en = 1; rdata_force = 32'hFFFFFF80;
        bus.ld_req = 1; bus.ld_addr = 32'h40; bus.ld_size = 3'd1; bus.ld_signed = 1;
        step();
        settle(200);
        rdata_force_en = 0;
        check("signed_ld_count", dlog.size(), 1);

        // IO store blocked by full UART buffer, fetch goes first
        dlog.delete();
        bus.io_buffer_full = 1;
        bus.st_req = 1; bus.st_addr = 32'h30000; bus.st_size = 3'd4; bus.st_data = $urandom();
        bus.if_req = 1; bus.if_addr = 32'h200;
        step();
        for (int k = 0; k < 200 && (m_busy || m_pend[P_IF]); k++) step();
        repeat (10) step();
        check("io_block_count", dlog.size(), 1);
        if (dlog.size() >= 1) check("io_block_first", dlog[0], P_IF);
        settle(200);
        check("io_release_count", dlog.size(), 2);
        if (dlog.size() == 2) check("io_release_second", dlog[1], P_ST);

        // flush during busy fetch with load and store pending
        dlog.delete();
        auto_mem = 0; bus.mem_done = 0;
        bus.if_req = 1; bus.if_addr = 32'h300;
        step();
        step();
        bus.ld_req = 1; bus.ld_addr = 32'h400; bus.ld_size = 3'd2; bus.ld_signed = 0;
        bus.st_req = 1; bus.st_addr = 32'h500; bus.st_size = 3'd4; bus.st_data = 32'h12345678;
        step();
        bus.flush = 1;
        step();
        repeat (3) step();
        bus.mem_done = 1;
        step();
        bus.mem_done = 0;
        settle(200);
        check("flush_count", dlog.size(), 1);
        if (dlog.size() == 1) check("flush_store_done", dlog[0], P_ST);

        // continuous loads with a waiting fetch
        dlog.delete();
        bus.if_req = 1; bus.if_addr = 32'h600;
        for (int k = 0; k < 300 && dlog.size() < 6; k++) begin
            bus.ld_req = 1; bus.ld_addr = $urandom(); bus.ld_size = rand_size(); bus.ld_signed = $urandom_range(0, 1);
            step();
        end
        check("starve_log_len", 32'(dlog.size() >= 6), 1);
        if (dlog.size() >= 6) begin
`ifdef STARVE_GUARD_EN
            for (int i = 0; i < 4; i++) check($sformatf("starve_ld%0d", i), dlog[i], P_LD);
            check("starve_if", dlog[4], P_IF);
`else
            n_if = 0;
            for (int i = 0; i < 6; i++) if (dlog[i] == P_IF) n_if++;
            check("strict_no_if", n_if, 0);
`endif
        end
        settle(300);

        // rdy low mid-transaction, mem_done during the freeze is ignored
        dlog.delete();
        auto_mem = 0; bus.mem_done = 0;
        bus.ld_req = 1; bus.ld_addr = 32'h800; bus.ld_size = 3'd2; bus.ld_signed = 0;
        step();
        step();
        step();
        rdy = 0; bus.mem_done = 1; bus.mem_rdata = 32'hA5A5_0001;
        repeat (5) step();
        rdy = 1; bus.mem_done = 0;
        step();
        bus.mem_done = 1; bus.mem_rdata = 32'h0000_BEEF;
        step();
        bus.mem_done = 0;
        settle(200);
        check("rdy_count", dlog.size(), 1);
        if (dlog.size() == 1) check("rdy_ld_done", dlog[0], P_LD);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) bus.io_buffer_full = ~bus.io_buffer_full;
            bus.flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.if_req = 1; bus.if_addr = $urandom();
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.ld_req = 1; bus.ld_addr = $urandom();
                bus.ld_size = rand_size(); bus.ld_signed = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.st_req = 1; bus.st_addr = $urandom();
                bus.st_size = rand_size(); bus.st_data = $urandom();
            end
            step();
        end
        settle(500);
        repeat (3) step();
        check("grant_queue_empty", gq.size(), 0);
        check("done_queue_empty", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
